// File: rtl/core_ifetch.sv
// Instruction-fetch stage: owns the architectural PC, issues one read at a
// time on the instruction-memory bus, and holds the fetched word for IF/ID.
// A flush while a read is in flight marks that read stale; its response is
// drained from the bus and dropped before the redirected PC is fetched.
module core_ifetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic [31:0] PC_NEXT,
  input  logic        PC_WRITE,
  input  logic        FLUSH,
  output logic [31:0] PC,
  output logic [31:0] INSTRUCTION,
  output logic        IMEM_BUSY,
  output logic        IMEM_DONE,
  output logic        FETCH_ERR,
  output logic        IMEM_ARVALID,
  input  logic        IMEM_ARREADY,
  output logic [31:0] IMEM_ARADDR,
  input  logic        IMEM_RVALID,
  output logic        IMEM_RREADY,
  input  logic [31:0] IMEM_RDATA,
  input  logic [1:0]  IMEM_RRESP
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  // Only the word address is kept; the byte offset is always zero on the bus.
  logic [29:0] araddr_q, araddr_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic        discard_q, discard_d;
  logic        done_q, done_d;
  logic        resp_err;

  assign resp_err = (IMEM_RRESP != 2'b00);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      araddr_q  <= RESET_PC[31:2];
      instr_q   <= NOP_INSTR;
      err_q     <= 1'b0;
      discard_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      araddr_q  <= araddr_d;
      instr_q   <= instr_d;
      err_q     <= err_d;
      discard_q <= discard_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: bus handshakes, flush/discard bookkeeping, PC update.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    araddr_d  = araddr_q;
    instr_d   = instr_q;
    err_d     = err_q;
    discard_d = discard_q;
    done_d    = 1'b0;
    case (state_q)
      S_REQ: begin
        // The address on the bus must not move while ARVALID is high, so a
        // flush only retargets the PC and marks the pending read stale.
        if (FLUSH) begin
          pc_d      = PC_NEXT;
          discard_d = 1'b1;
        end
        if (IMEM_ARREADY) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (IMEM_RVALID) begin
          if (discard_q || FLUSH) begin
            // Stale response: drop it and start the fetch at the current PC
            // (or the PC delivered by a flush arriving this very cycle).
            discard_d = 1'b0;
            state_d   = S_REQ;
            if (FLUSH) begin
              pc_d     = PC_NEXT;
              araddr_d = PC_NEXT[31:2];
            end else begin
              araddr_d = pc_q[31:2];
            end
          end else begin
            instr_d = resp_err ? NOP_INSTR : IMEM_RDATA;
            err_d   = resp_err;
            done_d  = 1'b1;
            state_d = S_HOLD;
          end
        end else if (FLUSH) begin
          pc_d      = PC_NEXT;
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (PC_WRITE || FLUSH) begin
          pc_d     = PC_NEXT;
          araddr_d = PC_NEXT[31:2];
          state_d  = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  assign IMEM_ARVALID = (state_q == S_REQ);
  assign IMEM_RREADY  = (state_q == S_WAIT);
  assign IMEM_ARADDR  = {araddr_q, 2'b00};
  assign IMEM_BUSY    = (state_q != S_HOLD);
  assign IMEM_DONE    = done_q;
  assign PC           = pc_q;
  assign INSTRUCTION  = (state_q == S_HOLD) ? instr_q : NOP_INSTR;
  assign FETCH_ERR    = (state_q == S_HOLD) && err_q;

endmodule

// File: doc/core_ifetch.md
Name: core_ifetch

Overview:
Instruction-fetch stage of the RV32I pipeline. It owns the architectural PC register and issues single-beat reads on the instruction-memory bus. It holds each fetched word stable for the IF/ID pipeline register and reports busy/done status to the hazard control unit. It accepts PC advance and redirect/flush commands from the control path. Outstanding fetches that a flush makes stale are discarded.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, word driven on INSTRUCTION when no valid instruction is held (addi x0,x0,0).

Ports:
CLK  in  1  clock.
NRST  in  1  synchronous active-low reset.
PC_NEXT  in  32  next PC from the PC-update logic (PC+4, branch or jump target).
PC_WRITE  in  1  advance request; PC <= PC_NEXT when honoured.
FLUSH  in  1  redirect: PC <= PC_NEXT unconditionally; any in-flight fetch becomes stale.
PC  out  32  address of the instruction held or being fetched.
INSTRUCTION  out  32  fetched instruction; NOP_INSTR unless in HOLD.
IMEM_BUSY  out  1  fetch in progress (state != HOLD).
IMEM_DONE  out  1  one-cycle pulse in the first HOLD cycle of a non-discarded fetch.
FETCH_ERR  out  1  high in HOLD when the held fetch returned an error response.
IMEM_ARVALID  out  1  read-address valid.
IMEM_ARREADY  in  1  read-address accepted.
IMEM_ARADDR  out  32  read address, word-aligned ({addr[31:2],2'b00}).
IMEM_RVALID  in  1  read-data valid.
IMEM_RREADY  out  1  read-data accept.
IMEM_RDATA  in  32  read data.
IMEM_RRESP  in  2  response; nonzero = error.

Behaviour:
- Reset, synchronous, NRST=0 at posedge. The following apply, and reset overrides all other inputs including mid-transaction:
  - pc_q=RESET_PC; state=REQ; discard=0; instr_q=NOP_INSTR; err_q=0.
  - Outputs after reset: ARVALID=1, ARADDR=RESET_PC, RREADY=0, BUSY=1, DONE=0, FETCH_ERR=0, INSTRUCTION=NOP_INSTR.
- FSM states:
  - REQ: ARVALID=1, ARADDR=araddr_q. araddr_q is loaded from pc_q on entry and is stable while ARVALID is high. On ARREADY go to WAIT.
  - WAIT: RREADY=1, ARVALID=0. On RVALID:
    - If discard=1: clear discard, reload araddr_q from pc_q, go to REQ. No DONE pulse.
    - Else: instr_q <= (RRESP!=0 ? NOP_INSTR : RDATA), err_q <= (RRESP!=0), DONE pulses next cycle, go to HOLD.
  - HOLD: BUSY=0; INSTRUCTION=instr_q; FETCH_ERR=err_q.
    - On PC_WRITE or FLUSH: pc_q <= PC_NEXT, go to REQ (araddr_q <= PC_NEXT).
- Command handling outside HOLD:
  - PC_WRITE is ignored in REQ and WAIT; the pipeline is stalled on BUSY.
  - FLUSH in REQ or WAIT: pc_q <= PC_NEXT, discard <= 1. The issued or pending request still completes on the bus; its data is dropped, then the new PC is fetched.
  - A FLUSH in REQ that coincides with ARREADY still sets discard.
  - Repeated FLUSH while discard=1: pc_q takes the latest PC_NEXT; discard stays 1; only one response is dropped.
  - FLUSH in the same cycle as a valid RVALID in WAIT: that response is dropped (discard takes effect that cycle), pc_q <= PC_NEXT, go to REQ.
  - PC_WRITE and FLUSH together: treated as FLUSH.
- Latency: ARREADY and RVALID granted immediately gives REQ → WAIT → HOLD. A new instruction is available every 3 cycles, with DONE in the HOLD cycle.
- Width and alignment:
  - pc_q is 32 bits; PC+4 wrap at 32'hFFFF_FFFC → 0 is the caller's arithmetic.
  - ARADDR bits [1:0] are forced to 0.
  - PC reports the unmodified pc_q.
- At most one outstanding transaction; RREADY is only high in WAIT.
- RVALID outside WAIT is ignored.

Test Plan:
- Reset release with RESET_PC=0; memory returns 32'h00500093 with zero wait → ARADDR=0 in cycle 1, HOLD in cycle 3, INSTRUCTION=32'h00500093, DONE pulses 1 cycle, BUSY=0.
- In HOLD, PC_WRITE=1 with PC_NEXT=4; RVALID delayed 5 cycles → BUSY=1 and INSTRUCTION=NOP 32'h13 throughout; PC=4; ARADDR=4 stable until ARREADY; DONE once.
- FLUSH with PC_NEXT=32'h100 in WAIT of fetch at 8 → response for 8 dropped (no DONE); next ARADDR=32'h100; HOLD shows data from 32'h100.
- FLUSH in REQ with ARREADY held low for 3 cycles → ARADDR stays 8 until accepted; response discarded; refetch at new PC.
- FLUSH coincident with RVALID, then a second FLUSH (PC_NEXT=32'h200) during the next REQ → only one DONE, for 32'h200; no stale word ever reaches INSTRUCTION.
- RRESP=2'b10 response → INSTRUCTION=32'h13, FETCH_ERR=1 in HOLD, cleared after next PC_WRITE; NRST=0 asserted mid-WAIT → next cycle state REQ, PC=RESET_PC, DONE=0.
